udma_eth_tx_packer: RTL and testbench

- Feeds the MAC transmit path of the uDMA Ethernet peripheral.
- Accepts 32-bit little-endian words from the uDMA TX channel and serialises them into the 8-bit AXI-Stream frame interface of the RGMII block (tx_axis_tdata/tvalid/tready/tlast/tuser).
- Frames are length-delimited by a configuration register; a software abort terminates the frame with tuser set.

---
 rtl/udma_eth_pkg.sv | 18 +
 rtl/udma_eth_tx_packer.sv | 151 +++++++++++++++
 tb/tb_udma_eth_tx_packer.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/udma_eth_pkg.sv
// Shared definitions for the uDMA Ethernet TX path: packer states and
// word/byte sizing helpers.
package udma_eth_pkg;

    localparam int ETH_BYTES_PER_WORD = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Number of 32-bit uDMA words that carry a frame of len bytes.
    function automatic logic [31:0] words_for_len(input logic [31:0] len);
        return (len + 32'd3) >> 2;
    endfunction

endpackage

// File: rtl/udma_eth_tx_packer.sv
// Serialises 32-bit little-endian uDMA TX words into an 8-bit AXI-Stream
// frame for the RGMII MAC, with length framing and software abort.
module udma_eth_tx_packer
    import udma_eth_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             cfg_start_i,
    input  logic [LEN_W-1:0] cfg_len_i,
    input  logic             cfg_abort_i,
    input  logic [31:0]      data_tx_i,
    input  logic             data_tx_valid_i,
    output logic             data_tx_ready_o,
    output logic [7:0]       tx_axis_tdata_o,
    output logic             tx_axis_tvalid_o,
    input  logic             tx_axis_tready_i,
    output logic             tx_axis_tlast_o,
    output logic             tx_axis_tuser_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             aborted_o,
    output logic [LEN_W-1:0] byte_cnt_o
);

    state_e           r_state;
    logic [31:0]      r_buf;
    logic             r_buf_vld;
    logic [1:0]       r_idx;
    logic [LEN_W-1:0] r_bytes_left;
    logic [LEN_W-1:0] r_words_left;
    logic [LEN_W-1:0] r_byte_cnt;
    logic             r_abort_pend;
    logic             r_done;
    logic             r_aborted;

    logic             w_send;
    logic             w_tvalid;
    logic             w_byte_hs;
    logic             w_last_len;
    logic             w_abort_now;
    logic             w_abort;
    logic             w_term_hs;
    logic             w_word_last;
    logic             w_ready;
    logic             w_word_hs;
    logic [LEN_W-1:0] w_words_next;

    assign w_send      = (r_state == ST_SEND);
    assign w_tvalid    = w_send & r_buf_vld;
    assign w_byte_hs   = w_tvalid & tx_axis_tready_i;
    assign w_last_len  = (r_bytes_left == LEN_W'(1));
    // An abort colliding with the natural tlast handshake is dropped; the
    // frame simply completes.
    assign w_abort_now = cfg_abort_i & w_send & ~r_abort_pend & ~(w_byte_hs & w_last_len);
    assign w_abort     = r_abort_pend | w_abort_now;
    assign w_term_hs   = w_byte_hs & (w_last_len | w_abort);
    assign w_word_last = (r_idx == 2'(ETH_BYTES_PER_WORD - 1));

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        w_ready = 1'b0;
        case (r_state)
            ST_SEND:  w_ready = (~r_buf_vld | (w_byte_hs & w_word_last)) & (r_words_left != '0);
            ST_DRAIN: w_ready = (r_words_left != '0);
            default:  w_ready = 1'b0;
        endcase
    end

    assign w_word_hs    = data_tx_valid_i & w_ready;
    assign w_words_next = r_words_left - LEN_W'(w_word_hs);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state      <= ST_IDLE;
            r_buf        <= '0;
            r_buf_vld    <= 1'b0;
            r_idx        <= '0;
            r_bytes_left <= '0;
            r_words_left <= '0;
            r_byte_cnt   <= '0;
            r_abort_pend <= 1'b0;
            r_done       <= 1'b0;
            r_aborted    <= 1'b0;
        end else begin
            r_done       <= 1'b0;
            r_words_left <= w_words_next;
            case (r_state)
                ST_IDLE: begin
                    if (cfg_start_i && (cfg_len_i != '0)) begin
                        r_state      <= ST_SEND;
                        r_bytes_left <= cfg_len_i;
                        r_words_left <= LEN_W'(words_for_len(32'(cfg_len_i)));
                        r_byte_cnt   <= '0;
                        r_buf_vld    <= 1'b0;
                        r_idx        <= '0;
                        r_abort_pend <= 1'b0;
                    end
                end
                ST_SEND: begin
                    if (w_abort_now && !w_byte_hs)
                        r_abort_pend <= 1'b1;
                    if (w_byte_hs) begin
                        r_bytes_left <= r_bytes_left - LEN_W'(1);
                        r_byte_cnt   <= r_byte_cnt + LEN_W'(1);
                        r_idx        <= r_idx + 2'd1;
                    end
                    // The terminating byte discards whatever is left of the buffer.
                    if (w_term_hs) begin
                        r_buf_vld    <= 1'b0;
                        r_abort_pend <= 1'b0;
                        if (w_abort && (w_words_next != '0)) begin
                            r_state <= ST_DRAIN;
                        end else begin
                            r_state   <= ST_IDLE;
                            r_done    <= 1'b1;
                            r_aborted <= w_abort;
                        end
                    end else if (w_word_hs) begin
                        r_buf     <= data_tx_i;
                        r_buf_vld <= 1'b1;
                        r_idx     <= '0;
                    end else if (w_byte_hs && w_word_last) begin
                        r_buf_vld <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (w_word_hs && (w_words_next == '0)) begin
                        r_state   <= ST_IDLE;
                        r_done    <= 1'b1;
                        r_aborted <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign data_tx_ready_o  = w_ready;
    assign tx_axis_tdata_o  = r_buf[{r_idx, 3'b000} +: 8];
    assign tx_axis_tvalid_o = w_tvalid;
    assign tx_axis_tlast_o  = w_tvalid & (w_last_len | w_abort);
    assign tx_axis_tuser_o  = w_tvalid & w_abort;
    assign busy_o           = (r_state != ST_IDLE);
    assign done_o           = r_done;
    assign aborted_o        = r_aborted;
    assign byte_cnt_o       = r_byte_cnt;

endmodule

// File: tb/tb_udma_eth_tx_packer.sv
// Table-driven and randomized bench for udma_eth_tx_packer; expected byte
// streams come from a frame-level model built from the word list.
module tb_udma_eth_tx_packer;

    localparam int LEN_W = 16;

    logic             clk_i = 1'b0;
    logic             rstn_i = 1'b0;
    logic             cfg_start_i = 1'b0;
    logic [LEN_W-1:0] cfg_len_i = '0;
    logic             cfg_abort_i = 1'b0;
    logic [31:0]      data_tx_i = '0;
    logic             data_tx_valid_i = 1'b0;
    logic             data_tx_ready_o;
    logic [7:0]       tx_axis_tdata_o;
    logic             tx_axis_tvalid_o;
    logic             tx_axis_tready_i = 1'b0;
    logic             tx_axis_tlast_o;
    logic             tx_axis_tuser_o;
    logic             busy_o;
    logic             done_o;
    logic             aborted_o;
    logic [LEN_W-1:0] byte_cnt_o;

    int n_vec = 0;
    int n_err = 0;

    udma_eth_tx_packer #(.LEN_W(LEN_W)) dut (
        .clk_i            (clk_i),
        .rstn_i           (rstn_i),
        .cfg_start_i      (cfg_start_i),
        .cfg_len_i        (cfg_len_i),
        .cfg_abort_i      (cfg_abort_i),
        .data_tx_i        (data_tx_i),
        .data_tx_valid_i  (data_tx_valid_i),
        .data_tx_ready_o  (data_tx_ready_o),
        .tx_axis_tdata_o  (tx_axis_tdata_o),
        .tx_axis_tvalid_o (tx_axis_tvalid_o),
        .tx_axis_tready_i (tx_axis_tready_i),
        .tx_axis_tlast_o  (tx_axis_tlast_o),
        .tx_axis_tuser_o  (tx_axis_tuser_o),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .aborted_o        (aborted_o),
        .byte_cnt_o       (byte_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [15:0] len;
        int          abort_at;   // abort once this many bytes have been handed over; 0 = none
        bit          stall;      // random tready and valid gaps
        bit          restart;    // pulse cfg_start_i mid-frame
        bit          fixed;      // use w0/w1 instead of random words
        logic [31:0] w0;
        logic [31:0] w1;
        int          exp_cnt;
        int          exp_words;
        bit          exp_aborted;
        bit          check_last;
        logic [7:0]  exp_last;
    } frame_vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        cfg_start_i      = 1'b0;
        cfg_abort_i      = 1'b0;
        data_tx_valid_i  = 1'b0;
        tx_axis_tready_i = 1'b0;
    endtask

    task automatic run_frame(input frame_vec_t v);
        logic [31:0] words[$];
        logic [7:0]  exp_b[$];
        int nw, n_exp, widx, nb, first_w, first_b, last_b;
        bit ab_sent, stalled_prev, seen_done;
        logic [7:0] prev_data, last_data;

        nw = (int'(v.len) + 3) / 4;
        for (int i = 0; i < nw; i++)
            words.push_back(v.fixed ? ((i == 0) ? v.w0 : v.w1) : $urandom);
        n_exp = (v.abort_at != 0) ? v.abort_at + 1 : int'(v.len);
        for (int k = 0; k < n_exp; k++)
            exp_b.push_back(8'(words[k / 4] >> (8 * (k % 4))));

        widx = 0; nb = 0; first_w = -1; first_b = -1; last_b = -1;
        ab_sent = 0; stalled_prev = 0; seen_done = 0;
        prev_data = '0; last_data = '0;

        @(posedge clk_i); #1;
        cfg_start_i = 1'b1;
        cfg_len_i   = v.len;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk_i); #1;
            cfg_start_i     = v.restart && (cyc == 3);
            cfg_len_i       = (v.restart && (cyc == 3)) ? 16'd3 : v.len;
            data_tx_valid_i = (widx < nw) && (!v.stall || ($urandom_range(0, 2) != 0));
            data_tx_i       = (widx < nw) ? words[widx] : $urandom;
            tx_axis_tready_i = !v.stall || ($urandom_range(0, 1) != 0);
            cfg_abort_i     = (v.abort_at != 0) && !ab_sent && (nb == v.abort_at);
            if (cfg_abort_i) ab_sent = 1;
            @(negedge clk_i);
            if (stalled_prev) begin
                check("stall_tvalid", 32'(tx_axis_tvalid_o), 32'd1);
                check("stall_tdata", 32'(tx_axis_tdata_o), 32'(prev_data));
            end
            if (data_tx_valid_i && data_tx_ready_o) begin
                if (widx == 0) first_w = cyc;
                widx++;
            end
            if (tx_axis_tvalid_o && tx_axis_tready_i) begin
                if (nb < n_exp) begin
                    check("byte_data", 32'(tx_axis_tdata_o), 32'(exp_b[nb]));
                    check("byte_tlast", 32'(tx_axis_tlast_o), 32'(nb == n_exp - 1));
                    check("byte_tuser", 32'(tx_axis_tuser_o), 32'((v.abort_at != 0) && (nb == n_exp - 1)));
                end else begin
                    check("extra_byte", 32'(nb), 32'(n_exp - 1));
                end
                if (nb == 0) first_b = cyc;
                last_b    = cyc;
                last_data = tx_axis_tdata_o;
                nb++;
            end
            stalled_prev = tx_axis_tvalid_o && !tx_axis_tready_i;
            prev_data    = tx_axis_tdata_o;
            if (done_o) begin
                seen_done = 1;
                check("done_busy", 32'(busy_o), 32'd0);
                check("done_aborted", 32'(aborted_o), 32'(v.exp_aborted));
                break;
            end
        end
        check("done_seen", 32'(seen_done), 32'd1);
        check("byte_cnt", 32'(byte_cnt_o), 32'(v.exp_cnt));
        check("bytes_total", 32'(nb), 32'(n_exp));
        check("words_accepted", 32'(widx), 32'(v.exp_words));
        if (v.check_last) check("last_byte", 32'(last_data), 32'(v.exp_last));
        if (!v.stall) begin
            check("first_latency", 32'(first_b - first_w), 32'd1);
            check("no_bubble", 32'(last_b - first_b), 32'(n_exp - 1));
        end
        @(posedge clk_i); #1;
        idle_inputs();
        @(negedge clk_i);
        check("done_pulse", 32'(done_o), 32'd0);
        check("cnt_hold", 32'(byte_cnt_o), 32'(v.exp_cnt));
    endtask

    frame_vec_t vecs[11];
    frame_vec_t rv;
    int nbytes;

    initial begin
        vecs[0]  = '{16'd8,  0, 0, 0, 1, 32'h44332211, 32'h88776655, 8,  2, 0, 1, 8'h88};
        vecs[1]  = '{16'd5,  0, 0, 0, 1, 32'hDDCCBBAA, 32'h000000EE, 5,  2, 0, 1, 8'hEE};
        vecs[2]  = '{16'd12, 0, 1, 0, 0, 32'h0, 32'h0,               12, 3, 0, 0, 8'h00};
        vecs[3]  = '{16'd16, 5, 0, 0, 0, 32'h0, 32'h0,               6,  4, 1, 0, 8'h00};
        vecs[4]  = '{16'd16, 5, 1, 0, 0, 32'h0, 32'h0,               6,  4, 1, 0, 8'h00};
        vecs[5]  = '{16'd1,  0, 0, 0, 0, 32'h0, 32'h0,               1,  1, 0, 0, 8'h00};
        vecs[6]  = '{16'd7,  0, 1, 1, 0, 32'h0, 32'h0,               7,  2, 0, 0, 8'h00};
        vecs[7]  = '{16'd3,  1, 0, 0, 0, 32'h0, 32'h0,               2,  1, 1, 0, 8'h00};
        vecs[8]  = '{16'd9,  6, 1, 0, 0, 32'h0, 32'h0,               7,  3, 1, 0, 8'h00};
        vecs[9]  = '{16'd4,  0, 0, 1, 0, 32'h0, 32'h0,               4,  1, 0, 0, 8'h00};
        vecs[10] = '{16'd33, 0, 1, 0, 0, 32'h0, 32'h0,               33, 9, 0, 0, 8'h00};

        // Reset state
        #2;
        check("rst_tvalid", 32'(tx_axis_tvalid_o), 32'd0);
        check("rst_ready", 32'(data_tx_ready_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_cnt", 32'(byte_cnt_o), 32'd0);
        repeat (2) @(posedge clk_i);
        #2 rstn_i = 1'b1;

        // Zero-length start is ignored
        @(posedge clk_i); #1;
        cfg_start_i = 1'b1;
        cfg_len_i   = '0;
        @(posedge clk_i); #1;
        cfg_start_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            check("len0_busy", 32'(busy_o), 32'd0);
            check("len0_done", 32'(done_o), 32'd0);
        end

        foreach (vecs[i]) run_frame(vecs[i]);

        // Reset mid-frame after three bytes
        @(posedge clk_i); #1;
        cfg_start_i = 1'b1;
        cfg_len_i   = 16'd8;
        @(posedge clk_i); #1;
        cfg_start_i = 1'b0;
        data_tx_valid_i  = 1'b1;
        data_tx_i        = 32'hA3A2A1A0;
        tx_axis_tready_i = 1'b1;
        nbytes = 0;
        for (int cyc = 0; cyc < 50 && nbytes < 3; cyc++) begin
            @(negedge clk_i);
            if (tx_axis_tvalid_o && tx_axis_tready_i) nbytes++;
            @(posedge clk_i); #1;
        end
        check("pre_rst_bytes", 32'(nbytes), 32'd3);
        rstn_i = 1'b0;
        idle_inputs();
        #1;
        check("midrst_tvalid", 32'(tx_axis_tvalid_o), 32'd0);
        check("midrst_tlast", 32'(tx_axis_tlast_o), 32'd0);
        check("midrst_busy", 32'(busy_o), 32'd0);
        check("midrst_cnt", 32'(byte_cnt_o), 32'd0);
        check("midrst_ready", 32'(data_tx_ready_o), 32'd0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        rv = '{16'd4, 0, 0, 0, 1, 32'h04030201, 32'h0, 4, 1, 0, 1, 8'h04};
        run_frame(rv);

        // Randomized frames
        for (int r = 0; r < 12; r++) begin
            rv.len      = 16'($urandom_range(1, 40));
            rv.abort_at = (rv.len >= 3 && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, int'(rv.len) - 2)) : 0;
            rv.stall    = $urandom_range(0, 1) != 0;
            rv.restart  = $urandom_range(0, 3) == 0;
            rv.fixed    = 0;
            rv.w0 = '0; rv.w1 = '0;
            rv.exp_cnt     = (rv.abort_at != 0) ? rv.abort_at + 1 : int'(rv.len);
            rv.exp_words   = (int'(rv.len) + 3) / 4;
            rv.exp_aborted = rv.abort_at != 0;
            rv.check_last  = 0;
            rv.exp_last    = '0;
            run_frame(rv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
